// File: rtl/idct_feed_ctrl.sv
// IDCT feed sequencer: buffers one coefficient block, replays it into the
// free-running core, and queues the core results behind a credit gate.
module idct_feed_ctrl #(
  parameter int DW        = 25,
  parameter int BEATS     = 4,
  parameter int LAT       = 8,
  parameter int GAP       = 1,
  parameter int OUT_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_d1,
  input  logic signed [DW-1:0] s_d2,
  input  logic signed [DW-1:0] s_d3,
  input  logic signed [DW-1:0] s_d4,
  output logic signed [DW-1:0] core_d1,
  output logic signed [DW-1:0] core_d2,
  output logic signed [DW-1:0] core_d3,
  output logic signed [DW-1:0] core_d4,
  input  logic signed [DW-1:0] core_q5,
  input  logic signed [DW-1:0] core_q6,
  input  logic signed [DW-1:0] core_q7,
  input  logic signed [DW-1:0] core_q8,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_d5,
  output logic signed [DW-1:0] m_d6,
  output logic signed [DW-1:0] m_d7,
  output logic signed [DW-1:0] m_d8,
  output logic                 m_last,
  output logic                 busy,
  output logic [15:0]          blk_cnt
);

  localparam int BW  = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int GW  = GAP > 1 ? $clog2(GAP) : 1;
  localparam int PW  = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
  localparam int CNW = $clog2(OUT_DEPTH + 1);
  localparam int CW  = CNW + 1;

  typedef logic [3:0][DW-1:0] beat_t;

  typedef struct packed {
    logic  last;
    beat_t d;
  } ent_t;

  typedef enum logic [1:0] {
    S_LOAD,
    S_ARM,
    S_FEED,
    S_GAP
  } state_e;

  state_e         st_q, st_d;
  logic [BW-1:0]  ld_q, ld_d;
  logic [BW-1:0]  fd_q, fd_d;
  logic [GW-1:0]  gp_q, gp_d;
  beat_t          cd_q, cd_d;
  logic           fv_q, fv_d;
  logic           fl_q, fl_d;
  logic [LAT-1:0] tv_q, tl_q;
  beat_t          ibuf_q [BEATS];
  ent_t           mem_q [OUT_DEPTH];
  ent_t           head;
  logic [PW-1:0]  wp_q, rp_q;
  logic [CNW-1:0] cnt_q, infl_q;
  logic [15:0]    blk_q;
  logic [CW-1:0]  occ;
  logic           accept, go, push, pop;

  assign s_ready = st_q == S_LOAD;
  assign accept  = s_valid && s_ready;
  assign occ     = CW'(cnt_q) + CW'(infl_q);
  assign go      = occ <= CW'(OUT_DEPTH - BEATS);
  assign push    = tv_q[LAT-1];
  assign m_valid = cnt_q != '0;
  assign pop     = m_valid && m_ready;

  always_comb begin
    st_d = st_q;
    ld_d = ld_q;
    fd_d = fd_q;
    gp_d = gp_q;
    cd_d = '0;
    fv_d = 1'b0;
    fl_d = 1'b0;
    unique case (st_q)
      S_LOAD: begin
        if (s_valid) begin
          ld_d = ld_q + BW'(1);
          if (ld_q == BW'(BEATS - 1)) begin
            ld_d = '0;
            st_d = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (go) begin
          fd_d = '0;
          st_d = S_FEED;
        end
      end
      S_FEED: begin
        cd_d = ibuf_q[fd_q];
        fv_d = 1'b1;
        fd_d = fd_q + BW'(1);
        if (fd_q == BW'(BEATS - 1)) begin
          fl_d = 1'b1;
          fd_d = '0;
          gp_d = '0;
          st_d = (GAP > 0) ? S_GAP : S_LOAD;
        end
      end
      S_GAP: begin
        gp_d = gp_q + GW'(1);
        if (gp_q == GW'(GAP - 1)) st_d = S_LOAD;
      end
      default: st_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= S_LOAD;
      ld_q <= '0;
      fd_q <= '0;
      gp_q <= '0;
      cd_q <= '0;
      fv_q <= 1'b0;
      fl_q <= 1'b0;
      tv_q <= '0;
      tl_q <= '0;
    end else begin
      st_q    <= st_d;
      ld_q    <= ld_d;
      fd_q    <= fd_d;
      gp_q    <= gp_d;
      cd_q    <= cd_d;
      fv_q    <= fv_d;
      fl_q    <= fl_d;
      tv_q[0] <= fv_q;
      tl_q[0] <= fl_q;
      for (int i = 1; i < LAT; i++) begin
        tv_q[i] <= tv_q[i-1];
        tl_q[i] <= tl_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) ibuf_q[ld_q] <= {s_d4, s_d3, s_d2, s_d1};
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {tl_q[LAT-1], core_q8, core_q7, core_q6, core_q5};
  end

  // In-flight count covers beats from issue until their result lands in the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
      blk_q  <= '0;
    end else begin
      infl_q <= infl_q + CNW'(fv_d) - CNW'(push);
      cnt_q  <= cnt_q + CNW'(push) - CNW'(pop);
      if (push) wp_q <= (wp_q == PW'(OUT_DEPTH - 1)) ? '0 : wp_q + PW'(1);
      if (pop) rp_q <= (rp_q == PW'(OUT_DEPTH - 1)) ? '0 : rp_q + PW'(1);
      if (pop && head.last) blk_q <= blk_q + 16'd1;
    end
  end

  always @(posedge clk) begin
    if (reset && push) assert (cnt_q != CNW'(OUT_DEPTH));
  end

  assign head    = mem_q[rp_q];
  assign m_d5    = m_valid ? head.d[0] : '0;
  assign m_d6    = m_valid ? head.d[1] : '0;
  assign m_d7    = m_valid ? head.d[2] : '0;
  assign m_d8    = m_valid ? head.d[3] : '0;
  assign m_last  = m_valid && head.last;
  assign core_d1 = cd_q[0];
  assign core_d2 = cd_q[1];
  assign core_d3 = cd_q[2];
  assign core_d4 = cd_q[3];
  assign blk_cnt = blk_q;
  assign busy    = !(st_q == S_LOAD && ld_q == '0 && infl_q == '0 && cnt_q == '0);

endmodule

// File: tb/tb_idct_feed_ctrl.sv
// Bench for idct_feed_ctrl: stub core is a LAT-deep delay line,
// output beats are checked against a scoreboard filled on upstream accept.
module tb_idct_feed_ctrl;
  localparam int DW        = 25;
  localparam int BEATS     = 4;
  localparam int LAT       = 8;
  localparam int GAP       = 1;
  localparam int OUT_DEPTH = 8;
  localparam int BV        = 4 * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_d1 = '0, s_d2 = '0, s_d3 = '0, s_d4 = '0;
  logic [DW-1:0] core_d1, core_d2, core_d3, core_d4;
  logic [DW-1:0] core_q5, core_q6, core_q7, core_q8;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_d5, m_d6, m_d7, m_d8;
  logic          m_last;
  logic          busy;
  logic [15:0]   blk_cnt;

  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            exp_blk = 0;
  logic [BV-1:0] blk [BEATS];
  logic [BV:0]   sb [$];
  logic [BV:0]   e;
  int            cd_runs [$];
  int            cd_starts [$];
  int            sr_runs [$];
  int            cd_run = 0;
  int            sr_run = 0;
  logic          hold_v = 1'b0;
  logic [BV+1:0] hold_e;
  logic [BV-1:0] dl [LAT];

  wire [BV-1:0] cdp = {core_d4, core_d3, core_d2, core_d1};
  wire [BV-1:0] mdp = {m_d8, m_d7, m_d6, m_d5};

  idct_feed_ctrl #(
    .DW(DW), .BEATS(BEATS), .LAT(LAT), .GAP(GAP), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_d1(s_d1), .s_d2(s_d2), .s_d3(s_d3), .s_d4(s_d4),
    .core_d1(core_d1), .core_d2(core_d2),
    .core_d3(core_d3), .core_d4(core_d4),
    .core_q5(core_q5), .core_q6(core_q6),
    .core_q7(core_q7), .core_q8(core_q8),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_d5(m_d5), .m_d6(m_d6), .m_d7(m_d7), .m_d8(m_d8),
    .m_last(m_last), .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    dl[0] <= cdp;
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end
  assign {core_q8, core_q7, core_q6, core_q5} = dl[LAT-1];

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [BV-1:0] mk(input int a, input int b,
                                       input int c, input int d);
    mk = {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [BV-1:0] rnd();
    rnd = {DW'($urandom), DW'($urandom), DW'($urandom),
           DW'($urandom) | DW'(1)};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      hold_v = 1'b0;
      cd_run = 0;
      sr_run = 0;
    end else begin
      if (hold_v) chk("hold", {m_valid, m_last, mdp}, hold_e);
      hold_v = m_valid && !m_ready;
      hold_e = {1'b1, m_last, mdp};
      if (m_valid && m_ready) begin
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk("beat", {m_last, mdp}, e);
        if (e[BV] === 1'b1) exp_blk++;
      end
      if (cdp != '0) begin
        if (cd_run == 0) cd_starts.push_back(cyc);
        cd_run++;
      end else if (cd_run > 0) begin
        cd_runs.push_back(cd_run);
        cd_run = 0;
      end
      if (!s_ready) sr_run++;
      else if (sr_run > 0) begin
        sr_runs.push_back(sr_run);
        sr_run = 0;
      end
    end
  end

  task automatic send(input bit tog, input bit hold);
    for (int k = 0; k < BEATS; k++) begin
      bit acc;
      int g;
      s_valid = 1'b1;
      {s_d4, s_d3, s_d2, s_d1} = blk[k];
      acc = 1'b0;
      g = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        g++;
        if (!acc && g > 300) begin
          n_err++;
          $display("FAIL accept_timeout beat=%0d", k);
          $fatal(1, "upstream stalled");
        end
      end
      sb.push_back({k == BEATS - 1, blk[k]});
      if (tog && k < BEATS - 1) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    if (!hold) s_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() > 0 || m_valid) && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_done", g < 1000, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cd_runs.delete();
    cd_starts.delete();
    sr_runs.delete();
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_core_d", cdp, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_d", mdp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single block
    blk[0] = mk(1440, -720, 0, 0);
    for (int k = 1; k < BEATS; k++) blk[k] = '0;
    send(0, 0);
    lat = -1;
    for (int n = 0; n < LAT + 8; n++) begin
      logic [BV-1:0] x;
      x = '0;
      if (n >= 2 && n < 2 + BEATS) x = blk[n-2];
      if (n < 8) chk($sformatf("cd_trace%0d", n), cdp, x);
      if (m_valid && lat < 0) lat = n;
      @(posedge clk);
      #1;
    end
    chk("latency", lat, LAT + 3);
    drain();
    chk("blk_single", blk_cnt, 1);

    // back-to-back, s_valid held
    clear_mon();
    blk[0] = mk(-720, 1440, -720, -720);
    send(0, 1);
    send(0, 0);
    drain();
    chk("b2b_sr_runs", sr_runs.size(), 2);
    if (sr_runs.size() >= 2) begin
      chk("b2b_sr_low0", sr_runs[0], 1 + BEATS + GAP);
      chk("b2b_sr_low1", sr_runs[1], 1 + BEATS + GAP);
    end
    chk("b2b_starts", cd_starts.size(), 2);
    if (cd_starts.size() >= 2)
      chk("b2b_spacing", cd_starts[1] - cd_starts[0], 2 * BEATS + GAP + 1);
    chk("blk_b2b", blk_cnt, 3);

    // downstream back-pressure
    clear_mon();
    m_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < BEATS; k++) blk[k] = rnd();
      send(0, b < 2);
    end
    repeat (40) @(posedge clk);
    #1;
    chk("bp_issued", cd_starts.size(), 2);
    chk("bp_core_idle", cdp, 0);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_busy", busy, 1);
    m_ready = 1'b1;
    drain();
    chk("bp_issued_all", cd_starts.size(), 3);
    chk("blk_bp", blk_cnt, 6);

    // upstream stalls every other clock
    clear_mon();
    for (int k = 0; k < BEATS; k++) blk[k] = rnd();
    send(1, 0);
    drain();
    chk("stall_runs", cd_runs.size(), 1);
    if (cd_runs.size() >= 1) chk("stall_feed_len", cd_runs[0], BEATS);
    chk("blk_stall", blk_cnt, 7);

    // reset during FEED with FIFO partly full
    m_ready = 1'b0;
    for (int k = 0; k < BEATS; k++) blk[k] = rnd();
    send(0, 1);
    for (int k = 0; k < BEATS; k++) blk[k] = rnd();
    send(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_m_valid", m_valid, 1);
    chk("pre_rst_core_d", cdp, blk[1]);
    #1 reset = 1'b0;
    #1;
    chk("ar_core_d", cdp, 0);
    chk("ar_m_valid", m_valid, 0);
    chk("ar_m_last", m_last, 0);
    chk("ar_m_d", mdp, 0);
    chk("ar_s_ready", s_ready, 1);
    chk("ar_busy", busy, 0);
    chk("ar_blk_cnt", blk_cnt, 0);
    sb.delete();
    exp_blk = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_ready", s_ready, 1);
    for (int k = 0; k < BEATS; k++) blk[k] = rnd();
    send(0, 0);
    drain();
    repeat (LAT + 10) @(posedge clk);
    #1;
    chk("post_rst_blk", blk_cnt, 1);

    // push and pop together with seven beats queued
    clear_mon();
    m_ready = 1'b0;
    for (int k = 0; k < BEATS; k++) blk[k] = rnd();
    send(0, 1);
    for (int k = 0; k < BEATS; k++) blk[k] = rnd();
    send(0, 0);
    repeat (LAT + 5) @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    chk("c7_m_valid", m_valid, 1);
    for (int k = 0; k < BEATS; k++) blk[k] = rnd();
    send(0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("c7_held", cd_starts.size(), 2);
    m_ready = 1'b1;
    drain();
    chk("c7_issued", cd_starts.size(), 3);

    // random downstream readiness
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          for (int k = 0; k < BEATS; k++) blk[k] = rnd();
          send(0, b < 2);
        end
      end
      begin
        repeat (120) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
      end
    join
    drain();
    chk("end_busy", busy, 0);
    chk("end_blk_model", blk_cnt, exp_blk);
    chk("end_blk", blk_cnt, 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
